// File: rtl/ann_pkg.sv
// Shared state encoding, size defaults and layer_out slot addressing for the
// ANN layer sequencer.
package ann_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int N_DEFAULT  = 10;
    localparam int M_DEFAULT  = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT,
        STORE,
        DONE
    } seq_state_t;

    // Bit offset of result slot idx inside a packed vector of dw-wide slots.
    function automatic int slot_offset(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/ann_seq_watchdog.sv
// WAIT-state timeout counter for ann_layer_sequencer; only compiled when
// ANN_SEQ_TIMEOUT_EN is defined.
`ifdef ANN_SEQ_TIMEOUT_EN
module ann_seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th enabled cycle, so the owner leaves WAIT
    // after exactly TIMEOUT cycles there.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/ann_layer_sequencer.sv
// Time-multiplexes one neuron datapath across the M outputs of a layer.
// Define ANN_SEQ_TIMEOUT_EN to add the WAIT-state timeout and sticky error flag.
module ann_layer_sequencer
    import ann_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int N       = N_DEFAULT,
    parameter int M       = M_DEFAULT,
    parameter int TIMEOUT = 255,
    localparam int AW     = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic              hidden_in,
    input  logic [DW*N-1:0]   in_vec,
    output logic [AW-1:0]     w_addr,
    input  logic [DW*N-1:0]   w_rdata,
    input  logic [DW-1:0]     b_rdata,
    output logic [DW*N-1:0]   n_value,
    output logic [DW*N-1:0]   n_weight,
    output logic [DW-1:0]     n_bias,
    output logic              n_hidden,
    output logic              n_start,
    input  logic [DW-1:0]     n_result,
    input  logic              n_ready,
    output logic [DW*M-1:0]   layer_out,
    output logic              busy,
    output logic              layer_done,
    output logic              error
);

    seq_state_t    state;
    logic          ready_q;
    logic [DW-1:0] result_q;
    logic          accept;

    // Only a fresh 0->1 ready edge counts; a level left over from the
    // previous neuron must not complete the current one.
    assign accept = (state == WAIT) && n_ready && !ready_q;

`ifdef ANN_SEQ_TIMEOUT_EN
    logic expired;

    ann_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == START),
        .enable  (state == WAIT),
        .expired (expired)
    );
`else
    // TIMEOUT is never negative, so this is constant 0 while still
    // referencing the parameter in this build.
    assign error = (TIMEOUT < 0);
`endif

    // w_addr is the neuron index itself; the ROM answers during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            w_addr     <= '0;
            ready_q    <= 1'b0;
            result_q   <= '0;
            n_value    <= '0;
            n_weight   <= '0;
            n_bias     <= '0;
            n_hidden   <= 1'b0;
            n_start    <= 1'b0;
            layer_out  <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
`ifdef ANN_SEQ_TIMEOUT_EN
            error      <= 1'b0;
`endif
        end else begin
            ready_q    <= n_ready;
            n_start    <= 1'b0;
            layer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (layer_start) begin
                        n_value  <= in_vec;
                        n_hidden <= hidden_in;
                        w_addr   <= '0;
                        busy     <= 1'b1;
`ifdef ANN_SEQ_TIMEOUT_EN
                        error    <= 1'b0;
`endif
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    n_weight <= w_rdata;
                    n_bias   <= b_rdata;
                    n_start  <= 1'b1;
                    state    <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (accept) begin
                        result_q <= n_result;
                        state    <= STORE;
                    end
`ifdef ANN_SEQ_TIMEOUT_EN
                    else if (expired) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`endif
                end
                STORE: begin
                    layer_out[slot_offset(int'(w_addr), DW) +: DW] <= result_q;
                    if (w_addr == AW'(M - 1)) begin
                        layer_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        w_addr <= w_addr + 1'b1;
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ann_layer_sequencer.md
Name: ann_layer_sequencer

Overview:
- Initiator side of the single-neuron start/ready handshake.
- Drives one shared neuron datapath once per neuron of a layer:
  - fetches that neuron's weight vector and bias from a synchronous weight ROM,
  - pulses start,
  - waits for ready,
  - stores the result into a layer output vector.
- Sits between the layer-level controller and the neuron instance; time-multiplexes one neuron across M outputs.

Parameters:
- DW, 8, data width of every value, weight, bias and result.
- N, 10, inputs per neuron (vector length).
- M, 4, neurons per layer; M >= 1.
- TIMEOUT, 255, max cycles waiting for ready; used only with ANN_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- layer_start  in  1  one-cycle request to run the layer; honoured only in IDLE.
- hidden_in  in  1  hidden-layer flag; captured at layer_start.
- in_vec  in  DW*N  layer input activations; captured at layer_start.
- w_addr  out  $clog2(M) (min 1)  weight ROM address = neuron index.
- w_rdata  in  DW*N  weight vector; valid one cycle after w_addr.
- b_rdata  in  DW  bias; same timing as w_rdata.
- n_value  out  DW*N  registered copy of in_vec to the neuron.
- n_weight  out  DW*N  captured weight vector.
- n_bias  out  DW  captured bias.
- n_hidden  out  1  captured hidden_in.
- n_start  out  1  one-cycle start pulse to the neuron.
- n_result  in  DW  neuron result; valid when n_ready rises.
- n_ready  in  1  neuron completion level.
- layer_out  out  DW*M  slot k (bits DW*k +: DW) holds neuron k's result.
- busy  out  1  high in every state except IDLE.
- layer_done  out  1  one-cycle pulse when all M results are stored.
- error  out  1  timeout flag; only with ANN_SEQ_TIMEOUT_EN, else tied 0.

Behaviour:
- Reset (async, any state): state IDLE, index 0.
  - All outputs and registers 0: n_start, busy, layer_done, error, layer_out, n_value, n_weight, n_bias, n_hidden, w_addr.
- States: IDLE, FETCH, LOAD, START, WAIT, STORE, DONE.
- IDLE:
  - On layer_start=1: capture in_vec into n_value and hidden_in into n_hidden; index<=0; go to FETCH.
  - layer_start in any other state is ignored; no queuing.
- FETCH: w_addr=index; go to LOAD.
- LOAD: n_weight<=w_rdata, n_bias<=b_rdata; go to START.
- START: n_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Accept the result on the rising edge of n_ready only: n_ready=1 and the registered previous n_ready=0.
  - A ready level still high from a previous neuron is never accepted.
  - On acceptance, register n_result; go to STORE.
- STORE:
  - Write the registered result to slot index.
  - If index==M-1 go to DONE; else index<=index+1 and go to FETCH.
- DONE: layer_done=1 for one cycle; go to IDLE.
- Timing:
  - Per-neuron overhead is 5 cycles plus W, where W = cycles spent in WAIT before acceptance.
  - layer_done asserts M*(5+W)+1 cycles after the layer_start edge, for constant W.
- layer_out slots keep their values until overwritten by the next run or reset. Slots not yet written in a run hold the previous run's values.
- n_value, n_weight and n_bias are stable from LOAD through STORE.
- M=1: STORE goes straight to DONE.
- Reset mid-run: abort immediately; layer_done is not pulsed.

Optional Feature:
- ANN_SEQ_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without acceptance: set error (sticky until the next accepted layer_start or rst); go to IDLE; no layer_done; layer_out partially updated.
- Not defined: WAIT waits forever, error is constant 0, and no counter logic is present.

Decomposition:
- Package ann_pkg holds:
  - state enum (IDLE..DONE),
  - DW/N/M defaults,
  - a slot-offset function idx*DW.
- One sub-module, ann_seq_watchdog: timeout counter with clear/enable inputs and an expired output. Instantiated only under ANN_SEQ_TIMEOUT_EN.

Test Plan:
- M=4, ROM returns bias=k for neuron k; the neuron model asserts ready 3 cycles after start with result=k+8'h10 → layer_out=32'h13121110, layer_done pulses once at cycle 4*(5+3)+1=33, busy high throughout.
- n_ready held high from before layer_start → no acceptance until ready drops and rises again; slot 0 is written only after that rise.
- layer_start pulsed again during WAIT with different in_vec → ignored; n_value unchanged; a single layer_done.
- rst asserted during neuron 2's WAIT → all outputs 0 next sample; no layer_done; a new layer_start then completes normally.
- M=1, ready after 1 cycle → layer_done 7 cycles after layer_start; only slot 0 written.
- ANN_SEQ_TIMEOUT_EN with TIMEOUT=8 and a neuron that never raises ready → error=1 after 8 WAIT cycles, state IDLE, no layer_done; the next good layer_start clears error.
